// File: rtl/fetch_queue_pkg.sv
// Shared types for the two-wide fetch queue: datapath width and the stored
// {pc, instr} entry.
package fetch_queue_pkg;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for fetch_queue: two write ports and two asynchronous read ports.
// The caller guarantees the two write indices never collide.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we0,
  input  logic [AW-1:0] waddr0,
  input  fetch_entry_t wdata0,
  input  logic         we1,
  input  logic [AW-1:0] waddr1,
  input  fetch_entry_t wdata1,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output fetch_entry_t rdata0,
  output fetch_entry_t rdata1
);
  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
endmodule

// File: rtl/fetch_queue.sv
// Two-wide in-order instruction queue between fetch and the decode register.
// Outputs depend only on registered pointers/count; flush and rst empty it in one edge.
module fetch_queue #(
  parameter int WIDTH = fetch_queue_pkg::WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            push_valid,
  input  logic [1:0][WIDTH-1:0] push_pc,
  input  logic [1:0][WIDTH-1:0] push_instr,
  output logic                  push_ready,
  input  logic [1:0]            pop_cnt,
  output logic [1:0]            out_valid,
  output logic [1:0][WIDTH-1:0] out_pc,
  output logic [1:0][WIDTH-1:0] out_instr,
  output logic [1:0][WIDTH-1:0] out_normal,
  output logic                  ovf_err
);
  import fetch_queue_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [1:0]    n_push, pop_req, pop_eff;
  logic          push_acc, clear;
  fetch_entry_t  wdata0, wdata1, rdata0, rdata1;

  assign clear      = rst | flush;
  assign push_ready = (count <= CW'(DEPTH - 2));
  assign push_acc   = push_ready & (|push_valid) & ~clear;
  assign n_push     = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};

  // A pop request of 3 behaves as 2, then is limited to what is actually held.
  always_comb begin
    pop_req = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
    pop_eff = pop_req;
    if (CW'(pop_req) > count) pop_eff = 2'(count);
  end

  // Compaction: the lone valid slot, or slot 0 of a pair, lands at wr_ptr.
  assign wdata0 = push_valid[0] ? '{pc: push_pc[0], instr: push_instr[0]}
                                : '{pc: push_pc[1], instr: push_instr[1]};
  assign wdata1 = '{pc: push_pc[1], instr: push_instr[1]};

  fetch_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk    (clk),
    .we0    (push_acc),
    .waddr0 (wr_ptr),
    .wdata0 (wdata0),
    .we1    (push_acc & (&push_valid)),
    .waddr1 (wr_ptr + AW'(1)),
    .wdata1 (wdata1),
    .raddr0 (rd_ptr),
    .raddr1 (rd_ptr + AW'(1)),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop_eff);
      count  <= count + (push_acc ? CW'(n_push) : CW'(0)) - CW'(pop_eff);
    end
  end

  // Overflow is sticky until reset; a flushing cycle's push is ignored entirely.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_err <= 1'b0;
    else if (!flush && (|push_valid) && !push_ready)
      ovf_err <= 1'b1;
  end

  assign out_valid[0] = (count >= CW'(1));
  assign out_valid[1] = (count >= CW'(2));

  always_comb begin
    out_pc     = '0;
    out_instr  = '0;
    out_normal = '0;
    if (out_valid[0]) begin
      out_pc[0]     = rdata0.pc;
      out_instr[0]  = rdata0.instr;
      out_normal[0] = rdata0.pc + WIDTH'(4);
    end
    if (out_valid[1]) begin
      out_pc[1]     = rdata1.pc;
      out_instr[1]  = rdata1.instr;
      out_normal[1] = rdata1.pc + WIDTH'(4);
    end
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Two-wide instruction queue between the fetch stage and the decode pipeline register. It accepts up to two {PC, instruction} pairs per cycle from fetch and presents the two oldest entries, in program order, to the decode register. It absorbs decode/issue back-pressure and supports a single-cycle flush on branch redirect.

## Interface
Parameters:
- WIDTH, 32, data/PC width (from shared package).
- DEPTH, 8, number of entries; power of two, ≥4.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all entries (branch redirect).
- push_valid  in  [1:0]  per-slot valid from fetch; slot 0 is older.
- push_pc  in  [WIDTH-1:0] x2  PC per slot.
- push_instr  in  [WIDTH-1:0] x2  instruction per slot.
- push_ready  out  1  high when free entries ≥ 2.
- pop_cnt  in  [1:0]  number of entries decode consumes this cycle (0, 1 or 2).
- out_valid  out  [1:0]  out slot 0 = oldest; out_valid[1] implies out_valid[0].
- out_pc  out  [WIDTH-1:0] x2  PC of out slot.
- out_instr  out  [WIDTH-1:0] x2  instruction of out slot.
- out_normal  out  [WIDTH-1:0] x2  out_pc + 4, modulo 2^WIDTH (feeds Normal_F).
- ovf_err  out  1  sticky: push attempted while push_ready was low.

## Operation
- State: rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), storage array.
- Push is accepted only when push_ready=1 and push_valid≠0.
  - Valid slots are compacted: 2'b01 and 2'b10 each write one entry at wr_ptr.
  - 2'b11 writes slot 0 at wr_ptr and slot 1 at wr_ptr+1.
  - wr_ptr advances by popcount(push_valid).
- A push while push_ready=0 is dropped, and ovf_err is set to 1 until rst.
- pop_eff = min(pop_cnt, count). pop_cnt=3 is treated as 2 and then clamped. rd_ptr advances by pop_eff.
- count_next = count + pushes_accepted − pop_eff. Simultaneous push and pop in one cycle are both applied.
- push_ready = (DEPTH − count) ≥ 2, computed from registered count only; there is no same-cycle pop credit.
- out_valid[0] = count≥1; out_valid[1] = count≥2. Out slot 1 reads index rd_ptr+1 mod DEPTH.
- out_pc, out_instr and out_normal are forced to 0 for any slot whose out_valid bit is 0.
- Flush takes priority over everything: pointers and count go to 0 and that cycle's push and pop are ignored. ovf_err is unaffected by flush.
- rst is identical to flush and also clears ovf_err. Array contents are not reset.

## Timing
- Reset values: out_valid=0, out_pc/out_instr/out_normal=0, push_ready=1, ovf_err=0.
- Push-to-output latency is 1 cycle: an entry written at edge N is visible on out_* after edge N. There is no empty-queue bypass.
- Pop takes effect at the edge. The next entries appear on out_* in the following cycle.
- push_ready, out_valid and out_* are combinational from registered state only. There is no combinational path from push_* or pop_cnt to any output.
- Flush or rst asserted at edge N: out_valid=0 and push_ready=1 after edge N, regardless of in-flight push or pop.

## Structure
- The shared package holds WIDTH and a typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_queue_ram: DEPTH x fetch_entry_t array with 2 write ports and 2 asynchronous read ports.
  - Write ports always target distinct indices.
  - The pointer/count control stays in fetch_queue.

## Test plan
- Reset then idle:
  - Required: out_valid=00, push_ready=1, ovf_err=0.
- Fill and drain:
  - Stimulus: push 11 {0x0/0x00000013, 0x4/0x00100093}, pop_cnt=0.
  - Required: next cycle out_valid=11, out_pc={0x0,0x4}, out_normal={0x4,0x8}.
  - Stimulus: pop_cnt=2.
  - Required: out_valid=00.
- Compaction and partial pop:
  - Stimulus: push 10 with PC 0x20, then push 01 with PC 0x24, then pop_cnt=1.
  - Required: before the pop, out_pc={0x20,0x24}; after it, out_valid=01 and out_pc[0]=0x24.
- Full and overflow (DEPTH=8):
  - Stimulus: push 3× 11 and 1× 01 (count=7).
  - Required: push_ready=0.
  - Stimulus: push 11.
  - Required: dropped, count stays 7, ovf_err=1.
  - Stimulus: pop_cnt=2.
  - Required: push_ready=1 next cycle.
- Wrap-around:
  - Stimulus: cycle 20 pairs with simultaneous push 11 and pop 2.
  - Required: PCs emerge in strict order with no gaps.
- Flush with simultaneous push and pop:
  - Stimulus: flush=1 with count=5, push 11 and pop_cnt=2 in the same cycle.
  - Required: count=0, out_valid=00, ovf_err unchanged.
